// File: rtl/deserializador_pkg.sv
// Shared definitions for the serial-to-parallel converter.
//   DATA_WIDTH : default word width in bits
//   state_t    : receiver FSM states
package deserializador_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic {
        RECEIVE  = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

endpackage

// File: rtl/deserializador.sv
// Serial-to-parallel converter. Shifts in DATA_WIDTH bits MSB first while
// write_in is high, then presents the word and holds it until ack_in.
// Ports:
//   clock_100KHz : system clock, rising-edge active
//   reset        : asynchronous active-low reset
//   ack_in       : consumer acknowledge of the presented word
//   data_in      : serial data bit
//   write_in     : data_in valid this cycle
//   status_out   : 1 = busy, word pending and serial input ignored
//   data_ready   : 1 = data_out holds a complete, unacknowledged word
//   data_out     : deserialized word, first received bit in the MSB
module deserializador
    import deserializador_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = deserializador_pkg::DATA_WIDTH
) (
    input  logic                  clock_100KHz,
    input  logic                  reset,
    input  logic                  ack_in,
    input  logic                  data_in,
    input  logic                  write_in,
    output logic                  status_out,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         bits_count;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  shift_en;
    logic                  load_word;

    assign shift_next = {shift[DATA_WIDTH-2:0], data_in};

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            state <= RECEIVE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        load_word  = 1'b0;
        case (state)
            RECEIVE: begin
                if (write_in) begin
                    shift_en = 1'b1;
                    if (bits_count == LAST_BIT) begin
                        load_word  = 1'b1;
                        state_next = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (ack_in) begin
                    state_next = RECEIVE;
                end
            end
            default: state_next = RECEIVE;
        endcase
    end

    // Flags track the next state so they rise on the same edge that loads
    // data_out and drop on the ack edge.
    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            shift      <= '0;
            bits_count <= '0;
            data_out   <= '0;
            data_ready <= 1'b0;
            status_out <= 1'b0;
        end else begin
            if (shift_en) begin
                shift      <= shift_next;
                bits_count <= load_word ? '0 : bits_count + CW'(1);
            end
            if (load_word) begin
                data_out <= shift_next;
            end
            data_ready <= (state_next == WAIT_ACK);
            status_out <= (state_next == WAIT_ACK);
        end
    end

endmodule

// File: tb/tb_deserializador.sv
// Scoreboard bench for deserializador: directed scenarios plus random words,
// checked against a bit-queue reference model.
module tb_deserializador;
    import deserializador_pkg::*;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         ack_in;
    logic         data_in;
    logic         write_in;
    logic         status_out;
    logic         data_ready;
    logic [W-1:0] data_out;

    deserializador #(.DATA_WIDTH(W)) dut (
        .clock_100KHz (clk),
        .reset        (rst_n),
        .ack_in       (ack_in),
        .data_in      (data_in),
        .write_in     (write_in),
        .status_out   (status_out),
        .data_ready   (data_ready),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit           m_bits[$];
    bit           m_busy;
    logic [W-1:0] m_word;
    logic [W-1:0] sb[$];
    bit           mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        sb.delete();
        m_busy = 1'b0;
        m_word = '0;
    endtask

    // One clock cycle: drive at the falling edge, apply the model's rules at
    // the rising edge, return at the next falling edge.
    task automatic cycle(input bit w, input bit d, input bit a);
        logic [W-1:0] word;
        write_in = w;
        data_in  = d;
        ack_in   = a;
        @(posedge clk);
        if (m_busy) begin
            if (a) m_busy = 1'b0;
        end else if (w) begin
            m_bits.push_back(d);
            if (m_bits.size() == W) begin
                word = '0;
                foreach (m_bits[i]) word = word * 2 + W'(m_bits[i]);
                m_word = word;
                sb.push_back(word);
                m_bits.delete();
                m_busy = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] word, input bit gaps);
        for (int i = W - 1; i >= 0; i--) begin
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                    cycle(1'b0, 1'($urandom), 1'($urandom));
            end
            cycle(1'b1, word[i], 1'b0);
        end
    endtask

    // Monitor: flags every cycle, scoreboard pop on each new presented word.
    bit prev_ready = 1'b0;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_ready = 1'b0;
        end else begin
            chk("data_ready", 32'(data_ready), 32'(m_busy));
            chk("status_out", 32'(status_out), 32'(m_busy));
            chk("data_out_held", 32'(data_out), 32'(m_word));
            if (data_ready && !prev_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'(0), 32'(1));
                end else begin
                    chk("sb_word", 32'(data_out), 32'(sb.pop_front()));
                end
            end
            prev_ready = data_ready;
        end
    end

    initial begin
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        ack_in   = 1'b0;
        data_in  = 1'b0;
        write_in = 1'b0;
        model_reset();

        // 1. Reset held with stimulus toggling
        for (int i = 0; i < 5; i++) begin
            #2;
            write_in = ~write_in;
            data_in  = ~data_in;
            ack_in   = ~ack_in;
        end
        @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_ready", 32'(data_ready), 32'h0);
        chk("rst_status_out", 32'(status_out), 32'h0);
        chk("rst_bits_count", 32'(dut.bits_count), 32'h0);
        chk("rst_state", 32'(dut.state == RECEIVE), 32'h1);
        ack_in = 1'b0; write_in = 1'b0; data_in = 1'b0;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 2. Gapped word
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("gap_bits_count", 32'(dut.bits_count), 32'd3);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'(~i[0]), 1'b0);
        chk("gap_word", 32'(data_out), 32'h55);
        chk("gap_ready", 32'(data_ready), 32'h1);
        chk("gap_busy", 32'(status_out), 32'h1);

        // 3. Bits written while busy are dropped
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("busy_word", 32'(data_out), 32'h55);
        chk("busy_bits_count", 32'(dut.bits_count), 32'h0);
        chk("busy_state", 32'(dut.state == WAIT_ACK), 32'h1);

        // 4. Ack held two cycles, then 0xA5
        cycle(1'b0, 1'b0, 1'b1);
        chk("ack_ready", 32'(data_ready), 32'h0);
        chk("ack_busy", 32'(status_out), 32'h0);
        cycle(1'b0, 1'b0, 1'b1);
        send_word(8'hA5, 1'b0);
        chk("a5_word", 32'(data_out), 32'hA5);
        cycle(1'b0, 1'b0, 1'b1);

        // 5. Back-to-back: ack on first ready cycle, next word immediately
        send_word(8'hFF, 1'b0);
        chk("ff_word", 32'(data_out), 32'hFF);
        cycle(1'b0, 1'b0, 1'b1);
        send_word(8'h00, 1'b0);
        chk("zero_word", 32'(data_out), 32'h00);
        chk("zero_ready", 32'(data_ready), 32'h1);
        cycle(1'b0, 1'b0, 1'b1);

        // Random words with gaps, dropped busy bits and varied ack delay
        for (int n = 0; n < 30; n++) begin
            send_word(W'($urandom), 1'($urandom));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                cycle(1'($urandom), 1'($urandom), 1'b0);
            cycle(1'($urandom), 1'($urandom), 1'b1);
        end

        // 6. Mid-word asynchronous reset between edges
        send_word(8'h3C, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data_out", 32'(data_out), 32'h0);
        chk("mid_rst_ready", 32'(data_ready), 32'h0);
        chk("mid_rst_busy", 32'(status_out), 32'h0);
        chk("mid_rst_bits_count", 32'(dut.bits_count), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        send_word(8'h96, 1'b0);
        chk("post_rst_word", 32'(data_out), 32'h96);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
